// File: rtl/sysid_check_if.sv
// Avalon-MM read-only bundle between the sysid checker (master) and the sysid slave.
interface sysid_check_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_check.sv
// Reads the sysid ID and timestamp words over Avalon-MM after reset (or on start)
// and reports whether both match the expected build values, with a per-read stall timeout.
module sysid_check #(
    parameter logic [31:0] EXPECTED_ID = 32'h0012_3456,
    parameter logic [31:0] EXPECTED_TS = 32'h5D82_94FE,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    sysid_check_if.master        avm,
    output logic [31:0]          id_word,
    output logic [31:0]          ts_word,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Abort fires on the edge that closes the TIMEOUT-th stalled cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    logic        avm_read_r;
    logic        avm_address_r;
    logic [31:0] id_word_r;
    logic [31:0] ts_word_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic        timeout_err_r;
    logic [15:0] wait_cnt_r;
    logic        stall_s;
    logic        timeout_hit_s;

    assign stall_s       = avm.avm_waitrequest;
    assign timeout_hit_s = stall_s && (wait_cnt_r == TIMEOUT_LAST);

    // Check sequencer: state, bus strobes, captured words and result flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            avm_read_r    <= 1'b0;
            avm_address_r <= 1'b0;
            id_word_r     <= 32'h0000_0000;
            ts_word_r     <= 32'h0000_0000;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            wait_cnt_r    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_RD_ID;
                    avm_read_r    <= 1'b1;
                    avm_address_r <= 1'b0;
                    busy_r        <= 1'b1;
                    done_r        <= 1'b0;
                    pass_r        <= 1'b0;
                    timeout_err_r <= 1'b0;
                    wait_cnt_r    <= 16'd0;
                end
                ST_RD_ID: begin
                    if (!stall_s) begin
                        id_word_r     <= avm.avm_readdata;
                        state_r       <= ST_RD_TS;
                        avm_address_r <= 1'b1;
                        wait_cnt_r    <= 16'd0;
                    end else if (timeout_hit_s) begin
                        // The timestamp read is skipped entirely.
                        state_r       <= ST_DONE;
                        avm_read_r    <= 1'b0;
                        avm_address_r <= 1'b0;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        pass_r        <= 1'b0;
                        timeout_err_r <= 1'b1;
                        wait_cnt_r    <= wait_cnt_r + 16'd1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
                end
                ST_RD_TS: begin
                    if (!stall_s) begin
                        ts_word_r     <= avm.avm_readdata;
                        state_r       <= ST_DONE;
                        avm_read_r    <= 1'b0;
                        avm_address_r <= 1'b0;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        pass_r        <= (id_word_r == EXPECTED_ID) &&
                                         (avm.avm_readdata == EXPECTED_TS);
                    end else if (timeout_hit_s) begin
                        state_r       <= ST_DONE;
                        avm_read_r    <= 1'b0;
                        avm_address_r <= 1'b0;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        pass_r        <= 1'b0;
                        timeout_err_r <= 1'b1;
                        wait_cnt_r    <= wait_cnt_r + 16'd1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r       <= ST_RD_ID;
                        avm_read_r    <= 1'b1;
                        avm_address_r <= 1'b0;
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                        timeout_err_r <= 1'b0;
                        wait_cnt_r    <= 16'd0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    avm_read_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign avm.avm_read    = avm_read_r;
    assign avm.avm_address = avm_address_r;
    assign id_word         = id_word_r;
    assign ts_word         = ts_word_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_sysid_check.sv
// Bench for sysid_check: a stall-programmable sysid slave, a table of directed runs,
// hand-written restart/reset sequences and randomized runs against an outcome model.
module tb_sysid_check;

    localparam int          T      = 4;
    localparam logic [31:0] EXP_ID = 32'h0012_3456;
    localparam logic [31:0] EXP_TS = 32'h5D82_94FE;
    localparam int          STUCK  = 1000;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_err;

    sysid_check_if bus ();

    sysid_check #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT(T)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus),
        .id_word     (id_word),
        .ts_word     (ts_word),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    int          cfg_stall [2];
    logic [31:0] cfg_data  [2];
    int          read_cycles [2];
    int          instab;
    int          stall_cnt;
    bit          prev_valid;
    bit          prev_stalled;
    logic        prev_addr;
    logic [31:0] exp_id_word;
    logic [31:0] exp_ts_word;

    // Slave: stalls each read for cfg_stall[addr] cycles, logs read cycles and address slips.
    always @(negedge clock) begin
        if (bus.avm_read !== 1'b1) begin
            bus.avm_waitrequest = 1'b0;
            stall_cnt           = 0;
            prev_valid          = 1'b0;
            prev_stalled        = 1'b0;
        end else begin
            if (!prev_valid || bus.avm_address != prev_addr) stall_cnt = 0;
            if (prev_valid && prev_stalled && bus.avm_address != prev_addr) instab++;
            bus.avm_waitrequest = (stall_cnt < cfg_stall[bus.avm_address]);
            bus.avm_readdata    = cfg_data[bus.avm_address];
            if (bus.avm_waitrequest) stall_cnt++;
            read_cycles[bus.avm_address]++;
            prev_stalled = bus.avm_waitrequest;
            prev_addr    = bus.avm_address;
            prev_valid   = 1'b1;
        end
    end

    typedef struct {
        int  lat;
        bit  pass;
        bit  to;
        int  rc0;
        int  rc1;
        bit  cap_id;
        bit  cap_ts;
    } res_t;

    // Outcome of one check from stall lengths: a read survives iff its stall is below T.
    function automatic res_t ref_model(int sid, int sts, logic [31:0] idv, logic [31:0] tsv);
        res_t r;
        r.cap_id = (sid < T);
        r.cap_ts = (sid < T) && (sts < T);
        r.to     = !r.cap_ts;
        r.rc0    = r.cap_id ? sid + 1 : T;
        r.rc1    = !r.cap_id ? 0 : (r.cap_ts ? sts + 1 : T);
        r.lat    = r.rc0 + r.rc1;
        r.pass   = !r.to && (idv == EXP_ID) && (tsv == EXP_TS);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_run(input string tag, input int sid, input int sts,
                          input logic [31:0] idv, input logic [31:0] tsv,
                          input bit by_reset, input int mid_k,
                          input int e_lat, input bit e_pass, input bit e_to);
        res_t r;
        int   lat;
        int   bad;
        r              = ref_model(sid, sts, idv, tsv);
        cfg_stall[0]   = sid;
        cfg_stall[1]   = sts;
        cfg_data[0]    = idv;
        cfg_data[1]    = tsv;
        read_cycles[0] = 0;
        read_cycles[1] = 0;
        instab         = 0;
        if (by_reset) reset_n = 1'b1;
        else          start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".entry_done"}, {30'd0, done, busy}, 32'd1);
        check({tag, ".entry_flags"}, {30'd0, pass, timeout_err}, 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            start = (lat == mid_k);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        if (r.cap_id) exp_id_word = idv;
        if (r.cap_ts) exp_ts_word = tsv;
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".pass"}, {31'd0, pass}, {31'd0, e_pass});
        check({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, e_to});
        check({tag, ".id_word"}, id_word, exp_id_word);
        check({tag, ".ts_word"}, ts_word, exp_ts_word);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b1 || busy !== 1'b0 || bus.avm_read !== 1'b0) bad++;
        end
        check({tag, ".done_hold"}, bad, 0);
        check({tag, ".rd_cycles0"}, read_cycles[0], r.rc0);
        check({tag, ".rd_cycles1"}, read_cycles[1], r.rc1);
        check({tag, ".addr_stable"}, instab, 0);
    endtask

    typedef struct {
        int          sid;
        int          sts;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
        bit          pass;
        bit          to;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0,     0,     EXP_ID,       EXP_TS,       2, 1'b1, 1'b0};
        tbl[1] = '{0,     0,     32'h0012_3457, EXP_TS,      2, 1'b0, 1'b0};
        tbl[2] = '{3,     3,     EXP_ID,       EXP_TS,       8, 1'b1, 1'b0};
        tbl[3] = '{STUCK, 0,     EXP_ID,       EXP_TS,       4, 1'b0, 1'b1};
        tbl[4] = '{1,     STUCK, EXP_ID,       EXP_TS,       6, 1'b0, 1'b1};
        tbl[5] = '{0,     0,     EXP_ID,       32'h5D82_94FF, 2, 1'b0, 1'b0};
        tbl[6] = '{4,     0,     EXP_ID,       EXP_TS,       4, 1'b0, 1'b1};
        tbl[7] = '{3,     0,     EXP_ID,       EXP_TS,       5, 1'b1, 1'b0};

        reset_n             = 1'b0;
        start               = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;
        exp_id_word         = 32'h0;
        exp_ts_word         = 32'h0;
        repeat (3) @(negedge clock);
        check("reset.read_addr", {30'd0, bus.avm_read, bus.avm_address}, 32'd0);
        check("reset.flags", {28'd0, busy, done, pass, timeout_err}, 32'd0);
        check("reset.id_word", id_word, 32'h0);
        check("reset.ts_word", ts_word, 32'h0);

        // First table entry runs straight out of reset, the rest are start-triggered.
        for (int i = 0; i < 8; i++) begin
            do_run($sformatf("tbl%0d", i), tbl[i].sid, tbl[i].sts, tbl[i].idv, tbl[i].tsv,
                   (i == 0), -1, tbl[i].lat, tbl[i].pass, tbl[i].to);
        end

        // Start during RD_TS is ignored; start on the DONE-entry edge is ignored too.
        do_run("rerun_mid", 0, 3, EXP_ID, EXP_TS, 1'b0, 2, 5, 1'b1, 1'b0);
        do_run("rerun_edge", 0, 0, EXP_ID, EXP_TS, 1'b0, 1, 2, 1'b1, 1'b0);

        // Reset while RD_TS is stalled.
        cfg_stall[0] = 0;
        cfg_stall[1] = STUCK;
        cfg_data[0]  = EXP_ID;
        cfg_data[1]  = EXP_TS;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("rst_mid.in_rd_ts", {30'd0, bus.avm_read, bus.avm_address}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.read_addr", {30'd0, bus.avm_read, bus.avm_address}, 32'd0);
        check("rst_mid.flags", {28'd0, busy, done, pass, timeout_err}, 32'd0);
        check("rst_mid.words", id_word | ts_word, 32'h0);
        exp_id_word = 32'h0;
        exp_ts_word = 32'h0;
        repeat (2) @(negedge clock);
        do_run("rst_rerun", 0, 0, EXP_ID, EXP_TS, 1'b1, -1, 2, 1'b1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int          sid;
            int          sts;
            logic [31:0] idv;
            logic [31:0] tsv;
            res_t        r;
            sid = $urandom_range(0, 5);
            sts = $urandom_range(0, 5);
            idv = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tsv = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            r   = ref_model(sid, sts, idv, tsv);
            do_run($sformatf("rnd%0d", n), sid, sts, idv, tsv, 1'b0, -1, r.lat, r.pass, r.to);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
